// File: rtl/frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// frame_sequencer_if
// Bundles the run control, ADC strobe, stage handshakes and status of the
// frame sequencer.
//   master : the sequencer side (drives frame_ready, the start pulses, status)
//   slave  : the surrounding front-end (drives enable, sample_valid, the done
//            pulses and clear_err)
// Signals:
//   enable, sample_valid, clear_err          run control / sample strobe / error clear
//   win_done, fft_done, feat_done            stage completion pulses
//   frame_ready, win_start, fft_start,
//   feat_start                               one-cycle pulses from the sequencer
//   busy, frame_count, overrun,
//   overrun_count, timeout_err               status
// -----------------------------------------------------------------------------
interface frame_sequencer_if;
    logic        enable;
    logic        sample_valid;
    logic        clear_err;
    logic        win_done;
    logic        fft_done;
    logic        feat_done;
    logic        frame_ready;
    logic        win_start;
    logic        fft_start;
    logic        feat_start;
    logic        busy;
    logic [15:0] frame_count;
    logic        overrun;
    logic [7:0]  overrun_count;
    logic        timeout_err;

    modport master (
        input  enable, sample_valid, clear_err, win_done, fft_done, feat_done,
        output frame_ready, win_start, fft_start, feat_start, busy,
               frame_count, overrun, overrun_count, timeout_err
    );

    modport slave (
        output enable, sample_valid, clear_err, win_done, fft_done, feat_done,
        input  frame_ready, win_start, fft_start, feat_start, busy,
               frame_count, overrun, overrun_count, timeout_err
    );
endinterface

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Counts ADC sample strobes to find complete (overlapping) frames in the
// framing buffer, then runs window -> FFT -> feature stages with start/done
// pulse handshakes. Frames arriving while the chain is busy are dropped and
// counted; a stage that never answers is aborted by a watchdog.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : frame_sequencer_if.master (control, handshakes, status)
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int FRAME_LEN   = 256,
    parameter int HOP_LEN     = 128,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    frame_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] FILL_TERM = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] HOP_TERM  = CNT_W'(HOP_LEN - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, WIN, FFT, FEAT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             frame_ready_q, frame_ready_d;
    logic             win_start_q, win_start_d;
    logic             fft_start_q, fft_start_d;
    logic             feat_start_q, feat_start_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       overrun_count_q, overrun_count_d;
    logic             timeout_q, timeout_d;

    logic             frame_event;
    logic             stage_done;
    logic             drop;
    logic             tout;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Sample counter: FRAME_LEN samples for the first frame after a (re)start,
    // then a new frame every HOP_LEN samples.
    always_comb begin
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        frame_event = 1'b0;
        if (!bus.enable) begin
            cnt_d  = '0;
            fill_d = 1'b1;
        end else if (bus.sample_valid) begin
            if (cnt_q == (fill_q ? FILL_TERM : HOP_TERM)) begin
                cnt_d       = '0;
                fill_d      = 1'b0;
                frame_event = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        stage_done = (state_q == WIN  && bus.win_done) ||
                     (state_q == FFT  && bus.fft_done) ||
                     (state_q == FEAT && bus.feat_done);
    end

    // Stage sequencing and watchdog. A done pulse always beats the watchdog;
    // the error is raised as the count reaches TIMEOUT_CYC and the stage is
    // abandoned on the following cycle.
    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        frame_ready_d = 1'b0;
        win_start_d   = 1'b0;
        fft_start_d   = 1'b0;
        feat_start_d  = 1'b0;
        frame_count_d = frame_count_q;
        drop          = 1'b0;
        tout          = 1'b0;
        if (state_q == IDLE) begin
            wdog_d = '0;
            if (frame_event) begin
                state_d       = WIN;
                frame_ready_d = 1'b1;
                win_start_d   = 1'b1;
            end
        end else if (stage_done) begin
            wdog_d = '0;
            case (state_q)
                WIN: begin
                    state_d     = FFT;
                    fft_start_d = 1'b1;
                    drop        = frame_event;
                end
                FFT: begin
                    state_d      = FEAT;
                    feat_start_d = 1'b1;
                    drop         = frame_event;
                end
                default: begin
                    // FEAT finishing frees the chain in time to accept a
                    // frame arriving in the same cycle.
                    frame_count_d = frame_count_q + 16'd1;
                    if (frame_event) begin
                        state_d       = WIN;
                        frame_ready_d = 1'b1;
                        win_start_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            endcase
        end else begin
            drop = frame_event;
            if (wdog_q == WD_MAX) begin
                state_d = IDLE;
                wdog_d  = '0;
            end else begin
                wdog_d = wdog_q + 1'b1;
                tout   = (wdog_q == WD_LAST);
            end
        end
    end

    // Error flags: a new event in the clearing cycle wins over the clear.
    always_comb begin
        overrun_d       = overrun_q;
        overrun_count_d = overrun_count_q;
        timeout_d       = timeout_q;
        if (bus.clear_err) begin
            overrun_d       = 1'b0;
            overrun_count_d = '0;
            timeout_d       = 1'b0;
        end
        if (drop) begin
            overrun_d       = 1'b1;
            overrun_count_d = bus.clear_err ? 8'd1 : sat_inc8(overrun_count_q);
        end
        if (tout) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            fill_q          <= 1'b1;
            wdog_q          <= '0;
            frame_ready_q   <= 1'b0;
            win_start_q     <= 1'b0;
            fft_start_q     <= 1'b0;
            feat_start_q    <= 1'b0;
            frame_count_q   <= '0;
            overrun_q       <= 1'b0;
            overrun_count_q <= '0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            fill_q          <= fill_d;
            wdog_q          <= wdog_d;
            frame_ready_q   <= frame_ready_d;
            win_start_q     <= win_start_d;
            fft_start_q     <= fft_start_d;
            feat_start_q    <= feat_start_d;
            frame_count_q   <= frame_count_d;
            overrun_q       <= overrun_d;
            overrun_count_q <= overrun_count_d;
            timeout_q       <= timeout_d;
        end
    end

    assign bus.frame_ready   = frame_ready_q;
    assign bus.win_start     = win_start_q;
    assign bus.fft_start     = fft_start_q;
    assign bus.feat_start    = feat_start_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.frame_count   = frame_count_q;
    assign bus.overrun       = overrun_q;
    assign bus.overrun_count = overrun_count_q;
    assign bus.timeout_err   = timeout_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
// Directed bench for frame_sequencer (FRAME_LEN=8, HOP_LEN=4, TIMEOUT_CYC=16).
// A cycle model derives the expected outputs from the total number of samples
// since the last fill restart and from the cycle on which each stage was
// entered; every output is compared against it on each falling edge. Literal
// hand-derived values are checked at key points of each scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_sequencer;
    localparam int FRAME_LEN = 8;
    localparam int HOP_LEN   = 4;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    frame_sequencer_if ifc();

    frame_sequencer #(
        .FRAME_LEN  (FRAME_LEN),
        .HOP_LEN    (HOP_LEN),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    // Stimulus: manual done pulses are OR-ed with the auto responders.
    logic en, sv, clr, m_win, m_fft, m_feat, r_win, r_fft, r_feat;
    bit   auto_win, auto_fft, auto_feat;
    assign ifc.enable       = en;
    assign ifc.sample_valid = sv;
    assign ifc.clear_err    = clr;
    assign ifc.win_done     = m_win  | r_win;
    assign ifc.fft_done     = m_fft  | r_fft;
    assign ifc.feat_done    = m_feat | r_feat;

    int vectors    = 0;
    int miscompares = 0;
    int fr_seen    = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int cyc;      // cycle index
        int samples;  // samples counted since the last fill restart
        int stage;    // 0 idle, 1 window, 2 fft, 3 feature
        int entry;    // cycle on which the current stage became active
        bit fr;
        bit ws;
        bit fs;
        bit ts;
        int fc;
        bit ov;
        int ovc;
        bit to;
    } model_t;

    model_t mdl;

    function automatic bit is_frame(input int n);
        if (n == FRAME_LEN) return 1'b1;
        if (n > FRAME_LEN && ((n - FRAME_LEN) % HOP_LEN) == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic model_t next_model(input model_t m, input bit e, input bit s,
                                          input bit wd, input bit fd, input bit td,
                                          input bit c);
        model_t n;
        bit ev, done, drop, tout;
        int age;
        n = m;
        ev = 1'b0; drop = 1'b0; tout = 1'b0;
        n.cyc = m.cyc + 1;
        n.fr = 1'b0; n.ws = 1'b0; n.fs = 1'b0; n.ts = 1'b0;
        if (!e) begin
            n.samples = 0;
        end else if (s) begin
            n.samples = m.samples + 1;
            ev = is_frame(n.samples);
        end
        done = (m.stage == 1 && wd) || (m.stage == 2 && fd) || (m.stage == 3 && td);
        age  = m.cyc - m.entry;
        if (m.stage == 0) begin
            if (ev) begin n.stage = 1; n.fr = 1'b1; n.ws = 1'b1; n.entry = n.cyc; end
        end else if (done) begin
            if (m.stage == 3) begin
                n.fc = (m.fc + 1) % 65536;
                if (ev) begin n.stage = 1; n.fr = 1'b1; n.ws = 1'b1; n.entry = n.cyc; end
                else n.stage = 0;
            end else begin
                n.stage = m.stage + 1;
                n.entry = n.cyc;
                if (m.stage == 1) n.fs = 1'b1; else n.ts = 1'b1;
                drop = ev;
            end
        end else begin
            drop = ev;
            if (age >= TIMEOUT) n.stage = 0;
            else if (age == TIMEOUT - 1) tout = 1'b1;
        end
        if (drop) begin
            n.ov  = 1'b1;
            n.ovc = c ? 1 : ((m.ovc < 255) ? m.ovc + 1 : 255);
        end else if (c) begin
            n.ov = 1'b0; n.ovc = 0;
        end
        if (tout) n.to = 1'b1;
        else if (c) n.to = 1'b0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) mdl <= '0;
        else     mdl <= next_model(mdl, ifc.enable, ifc.sample_valid, ifc.win_done,
                                   ifc.fft_done, ifc.feat_done, ifc.clear_err);
    end

    // Compare process: every output on every falling edge once reset has begun.
    bit started = 1'b0;
    always @(negedge clk) begin
        if (started) begin
            chk("frame_ready",   ifc.frame_ready,        mdl.fr);
            chk("win_start",     ifc.win_start,          mdl.ws);
            chk("fft_start",     ifc.fft_start,          mdl.fs);
            chk("feat_start",    ifc.feat_start,         mdl.ts);
            chk("busy",          ifc.busy,               int'(mdl.stage != 0));
            chk("frame_count",   int'(ifc.frame_count),  mdl.fc);
            chk("overrun",       ifc.overrun,            mdl.ov);
            chk("overrun_count", int'(ifc.overrun_count), mdl.ovc);
            chk("timeout_err",   ifc.timeout_err,        mdl.to);
            if (ifc.frame_ready) fr_seen++;
        end
    end

    // Auto responders: done pulse 2 cycles after the matching start pulse.
    int wcd, fcd, tcd;
    initial begin
        r_win = 0; r_fft = 0; r_feat = 0; wcd = 0; fcd = 0; tcd = 0;
        forever begin
            @(posedge clk); #1;
            r_win = 0; r_fft = 0; r_feat = 0;
            if (rst) begin
                wcd = 0; fcd = 0; tcd = 0;
            end else begin
                if (wcd > 0) begin wcd--; if (wcd == 0) r_win  = 1; end
                if (fcd > 0) begin fcd--; if (fcd == 0) r_fft  = 1; end
                if (tcd > 0) begin tcd--; if (tcd == 0) r_feat = 1; end
                if (ifc.win_start  && auto_win)  wcd = 2;
                if (ifc.fft_start  && auto_fft)  fcd = 2;
                if (ifc.feat_start && auto_feat) tcd = 2;
            end
        end
    end

    task automatic step(input bit s, input bit wd, input bit fd, input bit td, input bit c);
        @(posedge clk); #1;
        sv = s; m_win = wd; m_fft = fd; m_feat = td; clr = c;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; en = 0; sv = 0; clr = 0; m_win = 0; m_fft = 0; m_feat = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        fr_seen = 0;
    endtask

    initial begin
        en = 0; sv = 0; clr = 0; m_win = 0; m_fft = 0; m_feat = 0;
        auto_win = 0; auto_fft = 0; auto_feat = 0;
        #2 rst = 1;
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy",          ifc.busy, 0);
        chk("rst.frame_ready",   ifc.frame_ready, 0);
        chk("rst.frame_count",   int'(ifc.frame_count), 0);
        chk("rst.overrun_count", int'(ifc.overrun_count), 0);
        chk("rst.timeout_err",   ifc.timeout_err, 0);
        rst = 0;

        // Fill and hop: a sample every 3 cycles, all stages answer in 2 cycles.
        do_reset(); en = 1;
        auto_win = 1; auto_fft = 1; auto_feat = 1;
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            chk("hop.frame_ready", ifc.frame_ready, int'(i == 8 || i == 12 || i == 16));
            step(0, 0, 0, 0, 0);
        end
        repeat (12) step(0, 0, 0, 0, 0);
        chk("hop.frame_count", int'(ifc.frame_count), 3);
        chk("hop.fr_seen", fr_seen, 3);
        chk("hop.overrun", ifc.overrun, 0);

        // Overrun: window stage held off across two hops.
        do_reset(); en = 1;
        auto_win = 0; auto_fft = 1; auto_feat = 1;
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ovr.busy", ifc.busy, 1);
        chk("ovr.count_mid", int'(ifc.overrun_count), 2);
        step(0, 1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        chk("ovr.frame_count", int'(ifc.frame_count), 1);
        chk("ovr.overrun", ifc.overrun, 1);
        chk("ovr.overrun_count", int'(ifc.overrun_count), 2);
        chk("ovr.fr_seen", fr_seen, 1);

        // Frame event coincident with feat_done.
        do_reset(); en = 1;
        auto_win = 0; auto_fft = 0; auto_feat = 0;
        for (int c = 0; c < 14; c++)
            step(int'(c < 8 || c >= 10) != 0, c == 9, c == 11, c == 13, 0);
        step(0, 0, 0, 0, 0);
        chk("coin.win_start", ifc.win_start, 1);
        chk("coin.frame_ready", ifc.frame_ready, 1);
        chk("coin.frame_count", int'(ifc.frame_count), 1);
        chk("coin.overrun", ifc.overrun, 0);

        // Timeout: fft_done withheld.
        do_reset(); en = 1;
        auto_win = 1; auto_fft = 0; auto_feat = 1;
        for (int c = 0; c < 8; c++) step(1, 0, 0, 0, 0);
        for (int c = 8; c <= 28; c++) begin
            step(0, 0, 0, 0, 0);
            if (c == 11) chk("to.fft_start", ifc.fft_start, 1);
            if (c == 26) chk("to.err_before", ifc.timeout_err, 0);
            if (c == 27) begin
                chk("to.err", ifc.timeout_err, 1);
                chk("to.busy_at_err", ifc.busy, 1);
            end
            if (c == 28) begin
                chk("to.busy_after", ifc.busy, 0);
                chk("to.frame_count", int'(ifc.frame_count), 0);
            end
        end

        // fft_done on the 16th waiting cycle beats the watchdog.
        do_reset(); en = 1;
        for (int c = 0; c < 8; c++) step(1, 0, 0, 0, 0);
        for (int c = 8; c <= 30; c++) begin
            step(0, 0, c == 26, 0, 0);
            if (c == 27) begin
                chk("to2.feat_start", ifc.feat_start, 1);
                chk("to2.err", ifc.timeout_err, 0);
            end
            if (c == 30) chk("to2.frame_count", int'(ifc.frame_count), 1);
        end

        // Saturation, clear, and set-beats-clear.
        do_reset(); en = 1;
        auto_win = 0; auto_fft = 0; auto_feat = 0;
        repeat (1320) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        en = 0;
        repeat (25) step(0, 0, 0, 0, 0);
        chk("sat.overrun_count", int'(ifc.overrun_count), 255);
        chk("sat.overrun", ifc.overrun, 1);
        chk("sat.timeout_err", ifc.timeout_err, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("clr.overrun_count", int'(ifc.overrun_count), 0);
        chk("clr.overrun", ifc.overrun, 0);
        chk("clr.timeout_err", ifc.timeout_err, 0);
        en = 1;
        for (int i = 1; i <= 12; i++) step(1, 0, 0, 0, i == 12);
        step(0, 0, 0, 0, 0);
        chk("setwin.overrun", ifc.overrun, 1);
        chk("setwin.overrun_count", int'(ifc.overrun_count), 1);

        // Enable low restarts the fill.
        do_reset(); en = 1;
        auto_win = 1; auto_fft = 1; auto_feat = 1;
        repeat (5) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        en = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        en = 1;
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0, 0, 0);
            chk("en.no_early_frame", ifc.frame_ready, 0);
        end
        step(0, 0, 0, 0, 0);
        chk("en.frame_ready", ifc.frame_ready, 1);

        // Asynchronous reset in the middle of FFT.
        do_reset(); en = 1;
        auto_win = 1; auto_fft = 0; auto_feat = 0;
        for (int c = 0; c < 12; c++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("arst.busy_before", ifc.busy, 1);
        chk("arst.ovc_before", int'(ifc.overrun_count), 1);
        #2 rst = 1;
        #1;
        chk("arst.busy", ifc.busy, 0);
        chk("arst.overrun", ifc.overrun, 0);
        chk("arst.overrun_count", int'(ifc.overrun_count), 0);
        chk("arst.fft_start", ifc.fft_start, 0);
        chk("arst.frame_ready", ifc.frame_ready, 0);
        @(posedge clk); #1 rst = 0;
        repeat (3) step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
